iq_stream_player: RTL and testbench
===================================

// Module: iq_stream_player
// PURPOSE
//  Transmit-side counterpart of the scheduler's I/Q input: drives the two 32-bit I and Q AXIS
//  streams that the RF data converter normally supplies, from a frame loaded by the host.
//  Host streams packed {Q,I} words in, the block stores one frame, then replays it once,
//  N times or continuously at one sample per cycle. Used for loopback and regression of the TWN path.
// PARAMETERS
//  DEPTH   1024            max frame length in samples (words); power of two, >=2
//  ADDR_W  $clog2(DEPTH)   buffer address width (derived, do not override)
// PORTS
//  clk            in   1         system clock
//  rst            in   1         asynchronous reset, active-high
//  s_TDATA        in   64        frame word: [63:32]=Q word, [31:0]=I word
//  s_TVALID       in   1         frame word valid
//  s_TLAST        in   1         last word of frame
//  s_TREADY       out  1         frame word accepted
//  start          in   1         1-cycle pulse: begin playback of stored frame
//  abort          in   1         1-cycle pulse: stop playback / discard partial load
//  loop_count     in   16        playouts per start; 0 = continuous until abort; sampled at start
//  i_out_TDATA    out  32        I samples {I[2k+1],I[2k]} as stored
//  i_out_TVALID   out  1         I valid
//  i_out_TREADY   in   1         I ready
//  q_out_TDATA    out  32        Q samples as stored
//  q_out_TVALID   out  1         Q valid (always equal to i_out_TVALID)
//  q_out_TREADY   in   1         Q ready
//  frame_len      out  ADDR_W+1  words in stored frame (0 = none)
//  busy           out  1         high in PLAY
//  done           out  1         1-cycle pulse after final beat of last playout (not on abort)
//  overflow_err   out  1         sticky: a frame exceeded DEPTH; cleared by rst only
// BEHAVIOUR
//  Reset (async assert): state EMPTY; all TVALID, TDATA, busy, done, overflow_err, frame_len = 0;
//   s_TREADY = 0 while rst high. Buffer contents undefined (not cleared).
//  States: EMPTY, LOAD, DRAIN, LOADED, PLAY.
//  s_TREADY = 1 in EMPTY, LOAD, DRAIN, LOADED; 0 in PLAY.
//  EMPTY/LOADED + input beat: write addr 0, frame_len <= 0, go LOAD (LOADED frame is overwritten).
//   If that beat has TLAST: frame_len <= 1, go LOADED directly.
//  LOAD: each beat writes addr wr_ptr, wr_ptr++. Beat with TLAST -> frame_len <= wr_ptr+1, LOADED.
//   DEPTH-th beat without TLAST -> frame_len <= DEPTH, overflow_err <= 1, DRAIN.
//  DRAIN: accept and discard beats; TLAST beat -> LOADED.
//  abort in LOAD/DRAIN -> EMPTY, frame_len <= 0. start in EMPTY/LOAD/DRAIN ignored.
//  LOADED + start: latch loop_count into loops_left, rd_ptr <= 0, go PLAY, busy <= 1.
//   start and input beat in same cycle in LOADED: start wins, beat not accepted (s_TREADY=0 that cycle).
//  PLAY: buffer read latency 1 cycle; TVALID first high on 2nd rising edge after edge sampling start.
//   Beat transfers only when TVALID & i_out_TREADY & q_out_TREADY; I and Q advance together,
//   never individually (downstream consumes both jointly). TVALID/TDATA held stable until transfer.
//   Full throughput: one beat per cycle with readies high, including across frame wrap (no bubble).
//   After beat at addr frame_len-1: if loops_left==1 -> last playout; else wrap to addr 0,
//   loops_left-- (loops_left==0 never decrements: continuous).
//   Last beat of last playout transferred -> TVALID <= 0, busy <= 0, done pulses 1 cycle, LOADED.
//  abort in PLAY: TVALID <= 0 next edge even without handshake (permitted exception), no done,
//   -> LOADED, frame kept. abort with start same cycle in LOADED: abort wins (stay LOADED).
//  start in PLAY ignored. Readies low indefinitely: state and data frozen.
// TESTING
//  1) Load 4 words {Q=0x100+k, I=k}, TLAST on k=3; loop_count=1; start, readies high ->
//     frame_len=4, I=0,1,2,3 on 4 consecutive cycles from start+2, done 1 cycle after last, busy 0.
//  2) Same frame, loop_count=3 -> 12 back-to-back beats I=0..3 x3, no gap at wraps, one done.
//  3) loop_count=0, toggle i_out_TREADY 1/0 every cycle -> no beat skipped/duplicated over 40
//     transfers; abort -> TVALID 0 next cycle, no done, state LOADED, restart replays from I=0.
//  4) DEPTH=8, send 11 words TLAST on 11th -> overflow_err=1, frame_len=8, playback I=0..7.
//  5) Single-word frame (TLAST on first beat), loop_count=5 -> 5 consecutive beats same data.
//  6) Assert rst mid-PLAY -> TVALID/busy 0 immediately (async), frame_len=0, start ignored until reload.

Source files
------------

// File: rtl/iq_stream_player.sv
//------------------------------------------------------------------------------
// iq_stream_player
//
// Purpose:
//    Replays a host-loaded frame of packed {Q,I} words as two 32-bit AXIS
//    streams (I and Q) that move in lock-step. The frame is stored once in an
//    inferred block RAM and can then be played back once, N times, or
//    continuously at one beat per clock. It stands in for the RF data
//    converter on the transmit-side loopback / regression path.
//
// Ports:
//    clk, rst           clock, asynchronous active-high reset
//    s_TDATA/TVALID/    frame load stream: [63:32] = Q word, [31:0] = I word,
//    TLAST/TREADY       TLAST marks the final word of the frame
//    start              1-cycle pulse, begin playback of the stored frame
//    abort              1-cycle pulse, stop playback or discard a partial load
//    loop_count         playouts per start (0 = continuous), sampled on start
//    i_out_*            I sample stream (TDATA/TVALID/TREADY)
//    q_out_*            Q sample stream (TVALID always equals i_out_TVALID)
//    frame_len          number of words in the stored frame (0 = none)
//    busy               high while playing
//    done               1-cycle pulse after the final beat of the last playout
//    overflow_err       sticky, a loaded frame was longer than DEPTH
//------------------------------------------------------------------------------
module iq_stream_player #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [63:0]       s_TDATA,
   input  logic              s_TVALID,
   input  logic              s_TLAST,
   output logic              s_TREADY,
   input  logic              start,
   input  logic              abort,
   input  logic [15:0]       loop_count,
   output logic [31:0]       i_out_TDATA,
   output logic              i_out_TVALID,
   input  logic              i_out_TREADY,
   output logic [31:0]       q_out_TDATA,
   output logic              q_out_TVALID,
   input  logic              q_out_TREADY,
   output logic [ADDR_W:0]   frame_len,
   output logic              busy,
   output logic              done,
   output logic              overflow_err
);

   typedef enum logic [2:0] {
      ST_EMPTY,
      ST_LOAD,
      ST_DRAIN,
      ST_LOADED,
      ST_PLAY
   } state_t;

   localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   LEN_FULL  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH-1);

   state_t              r_state;

   // frame buffer and its registered read port
   logic [63:0]         r_mem [DEPTH];
   logic [63:0]         r_rd_data;

   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [ADDR_W-1:0]   r_rd_ptr;
   logic [15:0]         r_loops_left;
   logic [ADDR_W:0]     r_frame_len;

   // playback pipeline: read issue -> RAM output register -> AXIS output register
   logic                r_issue_active;
   logic                r_rd_vld;
   logic                r_rd_last;
   logic                r_out_valid;
   logic                r_out_last;
   logic [63:0]         r_out_data;

   logic                r_busy;
   logic                r_done;
   logic                r_ovf;

   logic                w_s_ready;
   logic                w_s_beat;
   logic                w_wr_en;
   logic [ADDR_W-1:0]   w_wr_addr;
   logic                w_xfer;
   logic                w_adv2;
   logic                w_rd_en;
   logic                w_rd_at_end;
   logic                w_last_loop;

   //---------------------------------------------------------------------------
   // Input side. A start pulse in LOADED takes priority over a load beat, so
   // ready is withdrawn combinationally for that cycle.
   //---------------------------------------------------------------------------
   assign w_s_ready = (r_state != ST_PLAY) && !((r_state == ST_LOADED) && start);
   assign s_TREADY  = w_s_ready && !rst;
   assign w_s_beat  = s_TVALID && w_s_ready;

   assign w_wr_en   = w_s_beat && ((r_state == ST_EMPTY) || (r_state == ST_LOADED) ||
                                   (r_state == ST_LOAD));
   // a new frame always starts at address 0
   assign w_wr_addr = (r_state == ST_LOAD) ? r_wr_ptr : '0;

   //---------------------------------------------------------------------------
   // Output side. The output register accepts a new word when it is empty or
   // its word is being transferred; the RAM register refills in the same cycle,
   // which sustains one beat per clock with both readies high.
   //---------------------------------------------------------------------------
   assign w_xfer      = r_out_valid && i_out_TREADY && q_out_TREADY;
   assign w_adv2      = r_rd_vld && (!r_out_valid || w_xfer);
   assign w_rd_en     = r_issue_active && (!r_rd_vld || w_adv2);
   assign w_rd_at_end = ({1'b0, r_rd_ptr} == (r_frame_len - LEN_ONE));
   assign w_last_loop = (r_loops_left == 16'd1);

   //---------------------------------------------------------------------------
   // Frame buffer: write port from the load stream, registered read port for
   // playback. Writes and reads never overlap because loading stops in PLAY.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[w_wr_addr] <= s_TDATA;
      end
      if (w_rd_en) begin
         r_rd_data <= r_mem[r_rd_ptr];
      end
   end

   //---------------------------------------------------------------------------
   // Control FSM and registered outputs
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_EMPTY;
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_loops_left   <= '0;
         r_frame_len    <= '0;
         r_issue_active <= 1'b0;
         r_rd_vld       <= 1'b0;
         r_rd_last      <= 1'b0;
         r_out_valid    <= 1'b0;
         r_out_last     <= 1'b0;
         r_out_data     <= '0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_ovf          <= 1'b0;
      end else begin
         r_done <= 1'b0;

         case (r_state)
            ST_EMPTY, ST_LOADED: begin
               if ((r_state == ST_LOADED) && start) begin
                  // abort arriving together with start cancels the start
                  if (!abort) begin
                     r_loops_left   <= loop_count;
                     r_rd_ptr       <= '0;
                     r_issue_active <= 1'b1;
                     r_rd_vld       <= 1'b0;
                     r_rd_last      <= 1'b0;
                     r_out_valid    <= 1'b0;
                     r_out_last     <= 1'b0;
                     r_busy         <= 1'b1;
                     r_state        <= ST_PLAY;
                  end
               end else if (w_s_beat) begin
                  // first word of a new frame went to address 0
                  r_wr_ptr <= PTR_ONE;
                  if (s_TLAST) begin
                     r_frame_len <= LEN_ONE;
                     r_state     <= ST_LOADED;
                  end else begin
                     r_frame_len <= '0;
                     r_state     <= ST_LOAD;
                  end
               end
            end

            ST_LOAD: begin
               if (abort) begin
                  r_frame_len <= '0;
                  r_state     <= ST_EMPTY;
               end else if (w_s_beat) begin
                  r_wr_ptr <= r_wr_ptr + PTR_ONE;
                  if (s_TLAST) begin
                     r_frame_len <= {1'b0, r_wr_ptr} + LEN_ONE;
                     r_state     <= ST_LOADED;
                  end else if (r_wr_ptr == PTR_LAST) begin
                     // buffer full and no end of frame yet: keep what fits,
                     // throw the rest away
                     r_frame_len <= LEN_FULL;
                     r_ovf       <= 1'b1;
                     r_state     <= ST_DRAIN;
                  end
               end
            end

            ST_DRAIN: begin
               if (abort) begin
                  r_frame_len <= '0;
                  r_state     <= ST_EMPTY;
               end else if (w_s_beat && s_TLAST) begin
                  r_state <= ST_LOADED;
               end
            end

            ST_PLAY: begin
               if (abort) begin
                  // drop valid without waiting for a handshake; frame is kept
                  r_issue_active <= 1'b0;
                  r_rd_vld       <= 1'b0;
                  r_out_valid    <= 1'b0;
                  r_busy         <= 1'b0;
                  r_state        <= ST_LOADED;
               end else begin
                  // read issue: walks the frame, wrapping per remaining loops
                  if (w_rd_en) begin
                     r_rd_vld  <= 1'b1;
                     r_rd_last <= w_rd_at_end && w_last_loop;
                     if (w_rd_at_end) begin
                        if (w_last_loop) begin
                           r_issue_active <= 1'b0;
                        end else begin
                           r_rd_ptr <= '0;
                           // loops_left == 0 means continuous: never counts down
                           if (r_loops_left != 16'd0) begin
                              r_loops_left <= r_loops_left - 16'd1;
                           end
                        end
                     end else begin
                        r_rd_ptr <= r_rd_ptr + PTR_ONE;
                     end
                  end else if (w_adv2) begin
                     r_rd_vld <= 1'b0;
                  end

                  // output register: I and Q always move as one beat
                  if (w_adv2) begin
                     r_out_valid <= 1'b1;
                     r_out_data  <= r_rd_data;
                     r_out_last  <= r_rd_last;
                  end else if (w_xfer) begin
                     r_out_valid <= 1'b0;
                  end

                  if (w_xfer && r_out_last) begin
                     r_out_valid <= 1'b0;
                     r_busy      <= 1'b0;
                     r_done      <= 1'b1;
                     r_state     <= ST_LOADED;
                  end
               end
            end

            default: begin
               r_state <= ST_EMPTY;
            end
         endcase
      end
   end

   assign i_out_TDATA  = r_out_data[31:0];
   assign q_out_TDATA  = r_out_data[63:32];
   assign i_out_TVALID = r_out_valid;
   assign q_out_TVALID = r_out_valid;
   assign frame_len    = r_frame_len;
   assign busy         = r_busy;
   assign done         = r_done;
   assign overflow_err = r_ovf;

endmodule

// File: tb/tb_iq_stream_player.sv
//------------------------------------------------------------------------------
// tb_iq_stream_player
//
// Directed and randomized bench for iq_stream_player (built with DEPTH = 8).
// The reference model is the stored frame as a queue; the expected output
// stream is simply that frame repeated loop_count times, in order.
//------------------------------------------------------------------------------
module tb_iq_stream_player;

   localparam int DEPTH = 8;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst;
   logic [63:0]   s_TDATA;
   logic          s_TVALID;
   logic          s_TLAST;
   logic          s_TREADY;
   logic          start;
   logic          abort;
   logic [15:0]   loop_count;
   logic [31:0]   i_out_TDATA;
   logic          i_out_TVALID;
   logic          i_out_TREADY;
   logic [31:0]   q_out_TDATA;
   logic          q_out_TVALID;
   logic          q_out_TREADY;
   logic [AW:0]   frame_len;
   logic          busy;
   logic          done;
   logic          overflow_err;

   iq_stream_player #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .s_TDATA      (s_TDATA),
      .s_TVALID     (s_TVALID),
      .s_TLAST      (s_TLAST),
      .s_TREADY     (s_TREADY),
      .start        (start),
      .abort        (abort),
      .loop_count   (loop_count),
      .i_out_TDATA  (i_out_TDATA),
      .i_out_TVALID (i_out_TVALID),
      .i_out_TREADY (i_out_TREADY),
      .q_out_TDATA  (q_out_TDATA),
      .q_out_TVALID (q_out_TVALID),
      .q_out_TREADY (q_out_TREADY),
      .frame_len    (frame_len),
      .busy         (busy),
      .done         (done),
      .overflow_err (overflow_err)
   );

   always #5 clk = ~clk;

   int            errors = 0;
   int            checks = 0;

   logic [63:0]   tx_words[$];
   logic [63:0]   model_frame[$];
   int            model_len = 0;
   logic          model_ovf = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ready(input int mode, input int k);
      case (mode)
         0: begin i_out_TREADY = 1'b1; q_out_TREADY = 1'b1; end
         1: begin i_out_TREADY = (k % 2 == 0); q_out_TREADY = 1'b1; end
         default: begin
            i_out_TREADY = ($urandom_range(0, 3) != 0);
            q_out_TREADY = ($urandom_range(0, 3) != 0);
         end
      endcase
   endtask

   // Send tx_words as one frame (TLAST on the final word), then update the model.
   task automatic load_frame();
      int n;
      n = tx_words.size();
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         s_TDATA  = tx_words[k];
         s_TVALID = 1'b1;
         s_TLAST  = (k == n - 1);
         #1;
         chk("s_tready_load", {63'd0, s_TREADY}, 64'd1);
      end
      @(negedge clk);
      s_TVALID = 1'b0;
      s_TLAST  = 1'b0;
      model_len = (n > DEPTH) ? DEPTH : n;
      model_frame.delete();
      for (int j = 0; j < model_len; j++) model_frame.push_back(tx_words[j]);
      if (n > DEPTH) model_ovf = 1'b1;
      chk("frame_len", 64'(frame_len), 64'(model_len));
      chk("overflow_err", {63'd0, overflow_err}, {63'd0, model_ovf});
      $display("load: %0d words sent, frame_len=%0d overflow=%0b", n, frame_len, overflow_err);
   endtask

   // Start playback and check every beat against the model stream.
   // abort_after != 0: pulse abort on the cycle of that transfer.
   task automatic play(input int loops, input int mode, input int abort_after, input bit timing);
      int k = 0;
      int beat = 0;
      int prev_k = 0;
      int last_k = -1;
      int abort_k = -1;
      int done_seen = 0;
      int total;
      logic [63:0] exp;
      total = (loops == 0) ? 0 : loops * model_len;
      @(negedge clk);
      loop_count = 16'(loops);
      start = 1'b1;
      set_ready(mode, 0);
      while (1) begin
         @(negedge clk);
         k++;
         start = 1'b0;
         abort = 1'b0;
         set_ready(mode, k);
         if (k == 1) chk("busy_after_start", {63'd0, busy}, 64'd1);
         if (done === 1'b1) done_seen++;
         if (i_out_TVALID === 1'b1) begin
            chk("q_valid_tracks_i", {63'd0, q_out_TVALID}, 64'd1);
            if (total != 0 && beat >= total) begin
               chk("valid_after_last_beat", {63'd0, i_out_TVALID}, 64'd0);
            end else begin
               exp = model_frame[beat % model_len];
               chk("i_data", 64'(i_out_TDATA), 64'(exp[31:0]));
               chk("q_data", 64'(q_out_TDATA), 64'(exp[63:32]));
               if (i_out_TREADY && q_out_TREADY) begin
                  if (timing && beat == 0) chk("first_beat_cycle", 64'(k), 64'd3);
                  if (mode == 0 && beat > 0) chk("beat_gap", 64'(k), 64'(prev_k + 1));
                  prev_k = k;
                  beat++;
                  if (total != 0 && beat == total) last_k = k;
                  if (abort_after != 0 && beat == abort_after) begin
                     abort   = 1'b1;
                     abort_k = k;
                  end
               end
            end
         end
         if (last_k >= 0 && k == last_k + 1) begin
            chk("done_after_last", {63'd0, done}, 64'd1);
            chk("busy_after_last", {63'd0, busy}, 64'd0);
            chk("valid_after_done", {63'd0, i_out_TVALID}, 64'd0);
         end
         if (last_k >= 0 && k == last_k + 2) begin
            chk("done_pulse_width", {63'd0, done}, 64'd0);
            chk("done_count", 64'(done_seen), 64'd1);
            break;
         end
         if (abort_k >= 0 && k == abort_k + 1) begin
            chk("valid_after_abort", {63'd0, i_out_TVALID}, 64'd0);
            chk("busy_after_abort", {63'd0, busy}, 64'd0);
         end
         if (abort_k >= 0 && k == abort_k + 3) begin
            chk("no_done_on_abort", 64'(done_seen), 64'd0);
            chk("loaded_after_abort", {63'd0, s_TREADY}, 64'd1);
            break;
         end
         if (k > 3000) begin
            chk("play_timeout_beats", 64'(beat), 64'(total));
            break;
         end
      end
      set_ready(0, 0);
      $display("play: loops=%0d mode=%0d beats=%0d cycles=%0d done_pulses=%0d", loops, mode, beat, k, done_seen);
   endtask

   initial begin
      rst          = 1'b1;
      s_TDATA      = '0;
      s_TVALID     = 1'b0;
      s_TLAST      = 1'b0;
      start        = 1'b0;
      abort        = 1'b0;
      loop_count   = '0;
      i_out_TREADY = 1'b1;
      q_out_TREADY = 1'b1;

      // reset state
      #1;
      chk("rst_s_tready", {63'd0, s_TREADY}, 64'd0);
      chk("rst_valid", {63'd0, i_out_TVALID}, 64'd0);
      chk("rst_idata", 64'(i_out_TDATA), 64'd0);
      chk("rst_frame_len", 64'(frame_len), 64'd0);
      chk("rst_busy_done_ovf", {61'd0, busy, done, overflow_err}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("empty_s_tready", {63'd0, s_TREADY}, 64'd1);
      $display("reset: released, frame_len=%0d", frame_len);

      // 1) four-word frame, single playout
      tx_words.delete();
      for (int k = 0; k < 4; k++) tx_words.push_back({32'h100 + 32'(k), 32'(k)});
      load_frame();
      play(1, 0, 0, 1'b1);

      // 2) three playouts, back to back across wraps
      play(3, 0, 0, 1'b1);

      // 3) continuous with toggling I ready, abort after 40 beats, then replay from 0
      play(0, 1, 40, 1'b0);
      play(1, 0, 0, 1'b1);

      // start together with abort in LOADED: abort wins
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      loop_count = 16'd1;
      #1;
      chk("start_blocks_load_ready", {63'd0, s_TREADY}, 64'd0);
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("abort_beats_start", {63'd0, busy}, 64'd0);
      $display("start+abort: busy=%0b", busy);

      // 5) single-word frame, five playouts
      tx_words.delete();
      tx_words.push_back(64'hCAFE_0001_BEEF_0001);
      load_frame();
      play(5, 0, 0, 1'b1);

      // 4) overflow: 11 words into an 8-deep buffer
      tx_words.delete();
      for (int k = 0; k < 11; k++) tx_words.push_back({32'h100 + 32'(k), 32'(k)});
      load_frame();
      play(1, 0, 0, 1'b1);

      // randomized frames, loop counts and backpressure
      for (int r = 0; r < 6; r++) begin
         int n;
         n = $urandom_range(1, 10);
         tx_words.delete();
         for (int k = 0; k < n; k++) tx_words.push_back({$urandom, $urandom});
         load_frame();
         play($urandom_range(1, 4), 2, 0, 1'b0);
      end

      // 6) async reset in the middle of continuous playback
      @(negedge clk);
      loop_count = 16'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_rst_valid", {63'd0, i_out_TVALID}, 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", {62'd0, i_out_TVALID, q_out_TVALID}, 64'd0);
      chk("async_rst_busy", {63'd0, busy}, 64'd0);
      chk("async_rst_frame_len", 64'(frame_len), 64'd0);
      chk("async_rst_s_tready", {63'd0, s_TREADY}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      model_ovf = 1'b0;
      chk("rst_clears_ovf", {63'd0, overflow_err}, {63'd0, model_ovf});
      @(negedge clk);
      start = 1'b1;
      loop_count = 16'd1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("start_ignored_empty", {62'd0, i_out_TVALID, busy}, 64'd0);
      end
      $display("reset mid-play: frame_len=%0d busy=%0b", frame_len, busy);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
